panel_monitor: RTL and testbench
================================

# panel_monitor

Health monitor that sits directly downstream of the NX4 panel driver.
- Consumes the driver's `led_blank` strobe and the panel's active-low `led_xerr` line.
- Counts frames and detects a stalled driver with a watchdog.
- Filters and latches panel errors.
- Drives the status LEDs and the gated CPLD watchdog pin `cpld_p8`, so a hung driver blanks the panel.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1048576: clock cycles without a `led_blank` rising edge before the block declares a stall; minimum 2.
- `XERR_FILTER`, default 4: consecutive low samples of synchronised `led_xerr` needed to register an error; minimum 1.
- `BLINK_BIT`, default 9: bit of `frame_count` that drives `status_yellow`; range 0–15.

Ports (one clock; reset is asynchronous and active-low):
- `clock`  in  1  system clock; the driver's outputs are synchronous to it.
- `reset_n`  in  1  asynchronous active-low reset.
- `led_blank`  in  1  driver BLANK strobe, same clock domain.
- `led_xerr`  in  1  panel error, active low, asynchronous.
- `clear_fault`  in  1  single-cycle pulse that clears the sticky flags.
- `cpld_p8`  out  1  gated copy of `led_blank` feeding the CPLD watchdog.
- `status_yellow`  out  1  frame heartbeat.
- `status_orange`  out  1  sticky "stall seen".
- `status_red`  out  1  panel error, live or latched.
- `fault`  out  1  OR of the two sticky flags.
- `frame_count`  out  16  number of `led_blank` rising edges, wrapping.

## Operation
- Edge detect: `blank_q` registers `led_blank`. `blank_rise = led_blank & ~blank_q`.
- Frame counter: increments by one on each `blank_rise`. Wraps from 0xFFFF to 0x0000.
- Watchdog counter:
  - Clears to 0 on `blank_rise`.
  - Otherwise increments, saturating at `TIMEOUT_CYCLES-1`.
  - `timeout` is true when the counter equals `TIMEOUT_CYCLES-1` and `blank_rise` is false.
- State machine, encoded as `IDLE`/`RUN`/`STALLED`:
  - `IDLE` → `RUN` on `blank_rise`.
  - `IDLE` → `STALLED` on `timeout`.
  - `RUN` → `STALLED` on `timeout`.
  - `STALLED` → `RUN` on `blank_rise`.
  - Entering `STALLED` sets the sticky flag `stall_seen`.
- `cpld_p8` is a registered output.
  - In `IDLE` and `RUN` it equals `led_blank` delayed by one cycle.
  - In `STALLED` it is forced to 0, so the CPLD watchdog starves and blanks the panel.
- Error path:
  - `led_xerr` passes through a 2-flop synchroniser whose flops reset to 1.
  - The low-run counter counts consecutive synchronised lows and saturates at `XERR_FILTER`. A single high sample resets it to 0.
  - `xerr_live` = (low-run counter == `XERR_FILTER`).
  - `xerr_live` sets the sticky flag `xerr_latched`.
- `clear_fault` clears `stall_seen` and `xerr_latched`.
  - If a set condition occurs in the same cycle, the set wins.
  - `clear_fault` does not change the state machine.
- Outputs:
  - `status_yellow = frame_count[BLINK_BIT]`.
  - `status_orange = stall_seen`.
  - `status_red = xerr_live | xerr_latched`.
  - `fault = stall_seen | xerr_latched`.

## Timing
- Reset values:
  - State `IDLE`; all counters 0.
  - `blank_q` 0; synchroniser flops 1; both sticky flags 0.
  - All outputs 0.
- `frame_count` shows the increment 1 cycle after the cycle in which `led_blank` first reads high.
- Stall timing: if the last `blank_rise` is in cycle n, the state becomes `STALLED` in cycle n+`TIMEOUT_CYCLES`. `status_orange` rises in the same cycle.
- `cpld_p8` tracks `led_blank` with 1 cycle latency. It goes low in the first `STALLED` cycle.
- Recovery: on `blank_rise` while `STALLED`, the state is `RUN` the next cycle and `cpld_p8` follows `led_blank` from then on.
- Error timing: `status_red` rises 2 (synchroniser) + `XERR_FILTER` cycles after `led_xerr` falls.
  - `xerr_latched` is set one cycle after `xerr_live` rises.
  - When `led_xerr` returns high, `xerr_live` falls 3 cycles later; `status_red` stays high via the latch.
- `blank_rise` in the same cycle the watchdog would saturate: the edge wins, the counter clears and no stall occurs.
- `reset_n` asserted mid-operation clears everything immediately and asynchronously. Release is synchronous to `clock`.

## Structure
- Package `panel_pkg`:
  - State enum `panel_state_t` (`IDLE`, `RUN`, `STALLED`).
  - Default constants `TIMEOUT_DEFAULT` and `XERR_FILTER_DEFAULT`.
- Sub-module `xerr_filter`: synchroniser plus low-run debounce. Output: `xerr_live`.
- Edge detect, counters, state machine and flags live in the top module. Expected size about 150 lines.

## Test plan
All scenarios use `TIMEOUT_CYCLES=100`, `XERR_FILTER=4`, `BLINK_BIT=3`.
- Reset with no `led_blank` activity:
  - Cycles 1–99 after reset release: state `IDLE`, `cpld_p8` follows `led_blank`.
  - Cycle 100: `STALLED`, `status_orange` = 1, `cpld_p8` = 0.
- 8-cycle high / 8-cycle low `led_blank` pulses, 20 pulses:
  - `frame_count` = 20, `status_yellow` toggles every 8 frames.
  - No stall; `cpld_p8` equals `led_blank` delayed 1 cycle throughout.
- Stop pulses for 120 cycles, then resume:
  - `STALLED` exactly 100 cycles after the last rise.
  - `RUN` 1 cycle after the next rise; `status_orange` stays 1 until `clear_fault`, then 0.
- `led_xerr` low for 3 cycles, then high: `status_red` stays 0.
- `led_xerr` low for 10 cycles:
  - `status_red` = 1 at cycle 6, and stays 1 after `led_xerr` returns high.
  - `clear_fault` asserted in the same cycle as a new timeout: `status_orange` remains 1.
- Assert `reset_n` low during `STALLED` with `frame_count` = 37: all outputs and counters are 0 immediately; normal operation resumes after release.

Source files
------------

// File: rtl/panel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : panel_pkg
// Description : Shared types and default constants for the NX4 panel health
//               monitor (state encoding, watchdog and error-filter defaults).
// Revision    : 1.0 - initial release
// ============================================================================
package panel_pkg;

    // Monitor state. IDLE until the first frame, RUN while frames arrive,
    // STALLED once the watchdog expires.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STALLED = 2'd2
    } panel_state_t;

    // Roughly 1M cycles without a BLANK edge declares a stalled driver.
    localparam int TIMEOUT_DEFAULT     = 1048576;
    // Consecutive low samples of the error line needed to call it real.
    localparam int XERR_FILTER_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/xerr_filter.sv
`default_nettype none
// ============================================================================
// Module      : xerr_filter
// Description : Synchronises the asynchronous active-low panel error line and
//               debounces it with a saturating low-run counter.
// Ports       : clock     - system clock
//               reset_n   - asynchronous active-low reset
//               led_xerr  - panel error, active low, asynchronous
//               xerr_live - high while the filtered error is present
// Revision    : 1.0 - initial release
// ============================================================================
module xerr_filter
    import panel_pkg::*;
#(
    parameter int XERR_FILTER = XERR_FILTER_DEFAULT
)(
    input  logic clock,
    input  logic reset_n,
    input  logic led_xerr,
    output logic xerr_live
);

    localparam int                 c_CNT_W  = $clog2(XERR_FILTER + 1);
    localparam logic [c_CNT_W-1:0] c_FILTER = c_CNT_W'(XERR_FILTER);

    logic               r_sync1;
    logic               r_sync2;
    logic [c_CNT_W-1:0] r_low_run;

    // Synchroniser flops reset to the inactive (high) level so reset never
    // looks like an error.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= led_xerr;
            r_sync2 <= r_sync1;
        end
    end

    // Any single high sample restarts the run; the count parks at the filter
    // length while the line stays low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_low_run <= '0;
        end else if (r_sync2) begin
            r_low_run <= '0;
        end else if (r_low_run != c_FILTER) begin
            r_low_run <= r_low_run + 1'b1;
        end
    end

    assign xerr_live = (r_low_run == c_FILTER);

endmodule
`default_nettype wire

// File: rtl/panel_monitor.sv
`default_nettype none
// ============================================================================
// Module      : panel_monitor
// Description : Health monitor downstream of the NX4 panel driver. Counts
//               frames, runs a stall watchdog, latches panel errors, drives
//               the status LEDs and gates the CPLD watchdog feed so a hung
//               driver blanks the panel.
// Ports       : clock, reset_n      - clock, async active-low reset
//               led_blank           - driver BLANK strobe (same domain)
//               led_xerr            - panel error, active low, asynchronous
//               clear_fault         - one-cycle pulse clearing sticky flags
//               cpld_p8             - gated, registered copy of led_blank
//               status_yellow       - frame heartbeat
//               status_orange       - sticky stall seen
//               status_red          - panel error, live or latched
//               fault               - OR of the sticky flags
//               frame_count[15:0]   - wrapping count of BLANK rising edges
// Revision    : 1.0 - initial release
// ============================================================================
module panel_monitor
    import panel_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int XERR_FILTER    = XERR_FILTER_DEFAULT,
    parameter int BLINK_BIT      = 9
)(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        led_blank,
    input  logic        led_xerr,
    input  logic        clear_fault,
    output logic        cpld_p8,
    output logic        status_yellow,
    output logic        status_orange,
    output logic        status_red,
    output logic        fault,
    output logic [15:0] frame_count
);

    localparam int                c_WD_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_WD_W-1:0] c_WD_MAX = c_WD_W'(TIMEOUT_CYCLES - 1);

    logic              r_blank_q;
    logic [15:0]       r_frame_count;
    logic [c_WD_W-1:0] r_wd_count;
    panel_state_t      r_state;
    panel_state_t      w_state_next;
    logic              r_cpld;
    logic              r_stall_seen;
    logic              r_xerr_latched;
    logic              w_blank_rise;
    logic              w_timeout;
    logic              w_stall_set;
    logic              w_xerr_live;

    assign w_blank_rise = led_blank & ~r_blank_q;
    // A BLANK edge in the saturating cycle wins: no timeout that cycle.
    assign w_timeout    = (r_wd_count == c_WD_MAX) & ~w_blank_rise;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_blank_q     <= 1'b0;
            r_frame_count <= '0;
            r_wd_count    <= '0;
        end else begin
            r_blank_q <= led_blank;
            if (w_blank_rise) begin
                r_frame_count <= r_frame_count + 16'd1;
                r_wd_count    <= '0;
            end else if (r_wd_count != c_WD_MAX) begin
                r_wd_count <= r_wd_count + 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state; the stall flag is set only on the transition into STALLED.
    always_comb begin
        w_state_next = r_state;
        w_stall_set  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_blank_rise) begin
                    w_state_next = RUN;
                end else if (w_timeout) begin
                    w_state_next = STALLED;
                    w_stall_set  = 1'b1;
                end
            end
            RUN: begin
                if (w_timeout) begin
                    w_state_next = STALLED;
                    w_stall_set  = 1'b1;
                end
            end
            STALLED: begin
                if (w_blank_rise) begin
                    w_state_next = RUN;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Starving the CPLD feed from the first STALLED cycle lets its own
    // watchdog blank the panel.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cpld <= 1'b0;
        end else begin
            r_cpld <= (w_state_next == STALLED) ? 1'b0 : led_blank;
        end
    end

    xerr_filter #(
        .XERR_FILTER (XERR_FILTER)
    ) u_xerr_filter (
        .clock     (clock),
        .reset_n   (reset_n),
        .led_xerr  (led_xerr),
        .xerr_live (w_xerr_live)
    );

    // Sticky flags: a set in the same cycle as clear_fault takes priority.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_seen   <= 1'b0;
            r_xerr_latched <= 1'b0;
        end else begin
            if (w_stall_set) begin
                r_stall_seen <= 1'b1;
            end else if (clear_fault) begin
                r_stall_seen <= 1'b0;
            end
            if (w_xerr_live) begin
                r_xerr_latched <= 1'b1;
            end else if (clear_fault) begin
                r_xerr_latched <= 1'b0;
            end
        end
    end

    assign cpld_p8       = r_cpld;
    assign frame_count   = r_frame_count;
    assign status_yellow = r_frame_count[BLINK_BIT];
    assign status_orange = r_stall_seen;
    assign status_red    = w_xerr_live | r_xerr_latched;
    assign fault         = r_stall_seen | r_xerr_latched;

endmodule
`default_nettype wire

// File: tb/tb_panel_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_panel_monitor
// Description : Self-checking bench for panel_monitor with a cycle-level
//               behavioural reference model (edge counts, sample history).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_panel_monitor;

    localparam int T = 100;
    localparam int F = 4;
    localparam int B = 3;

    logic        clock       = 1'b0;
    logic        reset_n     = 1'b0;
    logic        led_blank   = 1'b0;
    logic        led_xerr    = 1'b1;
    logic        clear_fault = 1'b0;
    logic        cpld_p8;
    logic        status_yellow;
    logic        status_orange;
    logic        status_red;
    logic        fault;
    logic [15:0] frame_count;

    int vectors = 0;
    int errors  = 0;

    panel_monitor #(
        .TIMEOUT_CYCLES (T),
        .XERR_FILTER    (F),
        .BLINK_BIT      (B)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .led_blank     (led_blank),
        .led_xerr      (led_xerr),
        .clear_fault   (clear_fault),
        .cpld_p8       (cpld_p8),
        .status_yellow (status_yellow),
        .status_orange (status_orange),
        .status_red    (status_red),
        .fault         (fault),
        .frame_count   (frame_count)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    bit          m_prev_blank;
    bit          m_stalled;
    bit          m_cpld;
    bit          m_stall_seen;
    bit          m_latched;
    int          m_since;     // edges since last sampled rise (or reset), capped
    logic [15:0] m_frames;
    bit          hist[$];     // led_xerr value sampled at each edge

    task automatic m_reset();
        m_prev_blank = 1'b0;
        m_stalled    = 1'b0;
        m_cpld       = 1'b0;
        m_stall_seen = 1'b0;
        m_latched    = 1'b0;
        m_since      = 0;
        m_frames     = 16'd0;
        hist.delete();
        for (int i = 0; i < 2 + F; i++) hist.push_back(1'b1);
    endtask

    // Error is live when the F samples that have crossed the 2-flop
    // synchroniser are all low.
    function automatic bit m_live();
        int n = hist.size();
        for (int j = 2; j < 2 + F; j++) if (hist[n - 1 - j]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [20:0] model_vec();
        return {m_cpld, m_frames[B], m_stall_seen, m_live() | m_latched,
                m_stall_seen | m_latched, m_frames};
    endfunction

    function automatic logic [20:0] dut_vec();
        return {cpld_p8, status_yellow, status_orange, status_red, fault, frame_count};
    endfunction

    // Advance one clock; inputs are held across the edge, outputs sampled 1 later.
    task automatic tick();
        bit rise, live_prev, stalled_new;
        @(posedge clock);
        if (!reset_n) begin
            m_reset();
        end else begin
            rise        = led_blank && !m_prev_blank;
            live_prev   = m_live();
            stalled_new = !rise && (m_since == T - 1);
            if (stalled_new && !m_stalled) m_stall_seen = 1'b1;
            else if (clear_fault)          m_stall_seen = 1'b0;
            if (live_prev)        m_latched = 1'b1;
            else if (clear_fault) m_latched = 1'b0;
            m_cpld    = stalled_new ? 1'b0 : led_blank;
            m_stalled = stalled_new;
            if (rise) begin
                m_since  = 0;
                m_frames = m_frames + 16'd1;
            end else if (m_since < T - 1) begin
                m_since++;
            end
            m_prev_blank = led_blank;
            hist.push_back(led_xerr);
            if (hist.size() > 16) void'(hist.pop_front());
        end
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0; led_blank = 1'b0; led_xerr = 1'b1; clear_fault = 1'b0;
        m_reset();
        repeat (3) tick();
        vectors++;
        if (dut_vec() !== 21'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected %h", dut_vec(), 21'd0);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_idle_stall();
        for (int k = 1; k <= T; k++) begin
            tick();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL idle_model k=%0d: got %h expected %h", k, dut_vec(), model_vec());
            end
            if (k == T - 1) begin
                vectors++;
                if (status_orange !== 1'b0) begin
                    errors++; $display("FAIL idle_early_orange: got %b expected 0", status_orange);
                end
            end
            if (k == T) begin
                vectors++;
                if ({status_orange, cpld_p8} !== 2'b10) begin
                    errors++; $display("FAIL idle_stall: got %b expected 10", {status_orange, cpld_p8});
                end
            end
        end
    endtask

    task automatic test_frames();
        for (int p = 0; p < 20; p++) begin
            for (int h = 0; h < 16; h++) begin
                led_blank   = (h < 8);
                clear_fault = (p == 0 && h == 0);
                tick();
                clear_fault = 1'b0;
                vectors++;
                if (dut_vec() !== model_vec()) begin
                    errors++; $display("FAIL frames_model p=%0d h=%0d: got %h expected %h", p, h, dut_vec(), model_vec());
                end
                vectors++;
                if (cpld_p8 !== led_blank) begin
                    errors++; $display("FAIL frames_cpld p=%0d h=%0d: got %b expected %b", p, h, cpld_p8, led_blank);
                end
                if (h == 15 && (p == 7 || p == 15)) begin
                    vectors++;
                    if (status_yellow !== (p == 7)) begin
                        errors++; $display("FAIL frames_yellow p=%0d: got %b expected %b", p, status_yellow, (p == 7));
                    end
                end
            end
        end
        vectors++;
        if ({frame_count, status_yellow, status_orange} !== {16'd20, 1'b0, 1'b0}) begin
            errors++; $display("FAIL frames_final: got %h expected %h", {frame_count, status_yellow, status_orange}, {16'd20, 2'b00});
        end
    endtask

    task automatic test_stall_recover();
        led_blank = 1'b1;
        tick();
        led_blank = 1'b0;
        for (int k = 1; k <= 120; k++) begin
            tick();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL stall_model k=%0d: got %h expected %h", k, dut_vec(), model_vec());
            end
            if (k == T - 1 || k == T) begin
                vectors++;
                if ({status_orange, cpld_p8} !== {(k == T), 1'b0}) begin
                    errors++; $display("FAIL stall_edge k=%0d: got %b expected %b", k, {status_orange, cpld_p8}, {(k == T), 1'b0});
                end
            end
        end
        led_blank = 1'b1;
        tick();
        vectors++;
        if ({cpld_p8, status_orange} !== 2'b11) begin
            errors++; $display("FAIL recover_cpld: got %b expected 11", {cpld_p8, status_orange});
        end
        led_blank = 1'b0;
        repeat (5) tick();
        vectors++;
        if (status_orange !== 1'b1) begin
            errors++; $display("FAIL orange_sticky: got %b expected 1", status_orange);
        end
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        vectors++;
        if ({status_orange, fault} !== 2'b00) begin
            errors++; $display("FAIL orange_cleared: got %b expected 00", {status_orange, fault});
        end
    endtask

    task automatic test_xerr_short();
        led_xerr = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            if (k == 4) led_xerr = 1'b1;
            tick();
            vectors++;
            if ({status_red, dut_vec()} !== {1'b0, model_vec()}) begin
                errors++; $display("FAIL xerr_short k=%0d: got %h expected %h", k, {status_red, dut_vec()}, {1'b0, model_vec()});
            end
        end
    endtask

    task automatic test_xerr_long();
        led_xerr = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 11) led_xerr = 1'b1;
            tick();
            vectors++;
            if (status_red !== (k >= 6)) begin
                errors++; $display("FAIL xerr_long_red k=%0d: got %b expected %b", k, status_red, (k >= 6));
            end
            vectors++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL xerr_long_model k=%0d: got %h expected %h", k, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_clear_vs_set();
        led_blank = 1'b1;
        tick();
        led_blank = 1'b0;
        for (int k = 1; k <= T; k++) begin
            clear_fault = (k == 5 || k == T);
            tick();
            clear_fault = 1'b0;
            vectors++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL clear_model k=%0d: got %h expected %h", k, dut_vec(), model_vec());
            end
            if (k == 5) begin
                vectors++;
                if ({fault, status_red} !== 2'b00) begin
                    errors++; $display("FAIL clear_xerr: got %b expected 00", {fault, status_red});
                end
            end
            if (k == T) begin
                vectors++;
                if (status_orange !== 1'b1) begin
                    errors++; $display("FAIL set_beats_clear: got %b expected 1", status_orange);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int p = 0; p < 14; p++) begin
            for (int h = 0; h < 4; h++) begin
                led_blank = (h < 2);
                tick();
                vectors++;
                if (dut_vec() !== model_vec()) begin
                    errors++; $display("FAIL pulses37 p=%0d: got %h expected %h", p, dut_vec(), model_vec());
                end
            end
        end
        repeat (T) tick();
        vectors++;
        if ({frame_count, status_orange, cpld_p8} !== {16'd37, 2'b10}) begin
            errors++; $display("FAIL pre_reset: got %h expected %h", {frame_count, status_orange, cpld_p8}, {16'd37, 2'b10});
        end
        reset_n = 1'b0;
        m_reset();
        #1;
        vectors++;
        if (dut_vec() !== 21'd0) begin
            errors++; $display("FAIL async_reset: got %h expected %h", dut_vec(), 21'd0);
        end
        tick();
        reset_n   = 1'b1;
        led_blank = 1'b1;
        tick();
        led_blank = 1'b0;
        vectors++;
        if ({frame_count, cpld_p8, status_orange} !== {16'd1, 2'b10}) begin
            errors++; $display("FAIL post_reset: got %h expected %h", {frame_count, cpld_p8, status_orange}, {16'd1, 2'b10});
        end
    endtask

    task automatic test_random();
        int blank_run = 0;
        int xerr_run  = 0;
        for (int i = 0; i < 4000; i++) begin
            if (blank_run == 0) begin
                led_blank = ~led_blank;
                if (!led_blank && $urandom_range(0, 15) == 0) blank_run = $urandom_range(95, 130);
                else                                          blank_run = $urandom_range(1, 10);
            end
            blank_run--;
            if (xerr_run == 0) begin
                led_xerr = ~led_xerr;
                xerr_run = led_xerr ? $urandom_range(5, 60) : $urandom_range(1, 8);
            end
            xerr_run--;
            clear_fault = ($urandom_range(0, 29) == 0);
            reset_n     = ($urandom_range(0, 1499) != 0);
            tick();
            reset_n     = 1'b1;
            clear_fault = 1'b0;
            vectors++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL random i=%0d: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_stall();
        test_frames();
        test_stall_recover();
        test_xerr_short();
        test_xerr_long();
        test_clear_vs_set();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
